// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: default widths, FSM encodings and
// the channel-index width helper.
package mem_arbiter_pkg;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WAIT_CYC = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin picker: first unmasked requester at or after last_grant+1,
// wrapping modulo NUM_CH.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic [IDX_W-1:0]  grant_o,
  output logic              valid_o
);

  logic [NUM_CH-1:0] eff;

  assign eff     = req_i & ~mask_i;
  assign valid_o = |eff;

  // Smallest rotational distance from last_grant+1 wins.
  always_comb begin : pick
    int off;
    int best_off;
    off      = 0;
    best_off = NUM_CH;
    grant_o  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      off = c - int'(last_grant_i) - 1;
      if (off < 0) off = off + NUM_CH;
      if (eff[c] && (off < best_off)) begin
        best_off = off;
        grant_o  = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel asynchronous-SRAM arbiter with round-robin grant and a
// fixed-length strobe sequence per access.
//
// state  | meaning
// IDLE   | arbitrate; served channel masked for one cycle after DONE
// SETUP  | address/data valid, ce_n low, oe_n/we_n high
// ACCESS | oe_n or we_n low for WAIT_CYC cycles
// DONE   | strobes released, ch_done pulse to served channel
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_rd,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic                     ram_data_oe,
  output logic                     ram_ce_n,
  output logic                     ram_oe_n,
  output logic                     ram_we_n
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mask_first_q, mask_first_d;

  logic [NUM_CH-1:0] served_oh;
  logic [NUM_CH-1:0] mask;
  logic [IDX_W-1:0]  grant;
  logic              grant_valid;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    served_oh = '0;
    for (int c = 0; c < NUM_CH; c++) served_oh[c] = (ch_q == IDX_W'(c));
  end

  assign mask = mask_first_q ? served_oh : '0;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req_i        (ch_rd | ch_wr),
    .last_grant_i (last_q),
    .mask_i       (mask),
    .grant_o      (grant),
    .valid_o      (grant_valid)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == IDX_W'(c)) begin
        sel_wr    = ch_wr[c];
        sel_addr  = ch_addr[c*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ch_d         = ch_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    mask_first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write wins when a channel raises both rd and wr.
        if (grant_valid) begin
          state_d = ST_SETUP;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          ch_d    = grant;
          last_d  = grant;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYC - 1);
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!wr_q) rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        mask_first_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ch_q         <= '0;
      last_q       <= IDX_W'(NUM_CH - 1);
      cnt_q        <= '0;
      rdata_q      <= '0;
      mask_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ch_q         <= ch_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      mask_first_q <= mask_first_d;
    end
  end

  // Strobes decode straight from registered state so reset forces them high at once.
  assign busy        = (state_q != ST_IDLE);
  assign ram_ce_n    = !((state_q == ST_SETUP) || (state_q == ST_ACCESS));
  assign ram_oe_n    = !((state_q == ST_ACCESS) && !wr_q);
  assign ram_we_n    = !((state_q == ST_ACCESS) && wr_q);
  assign ram_data_oe = wr_q && (state_q != ST_IDLE);
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ch_rdata    = rdata_q;
  assign ch_done     = (state_q == ST_DONE) ? served_oh : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NUM_CH=2, WAIT_CYC=2) with a tiny SRAM model
// and a done-event scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  ch_rd;
  logic [1:0]  ch_wr;
  logic [35:0] ch_addr;
  logic [31:0] ch_wdata;
  logic [1:0]  ch_done;
  logic [15:0] ch_rdata;
  logic        busy;
  logic [17:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_data_oe;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(18), .DATA_W(16), .WAIT_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_rd       (ch_rd),
    .ch_wr       (ch_wr),
    .ch_addr     (ch_addr),
    .ch_wdata    (ch_wdata),
    .ch_done     (ch_done),
    .ch_rdata    (ch_rdata),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_data_oe (ram_data_oe),
    .ram_ce_n    (ram_ce_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [64];
  initial foreach (mem[i]) mem[i] = 16'h0;
  always @(posedge clk) if (!ram_ce_n && !ram_we_n) mem[ram_addr[5:0]] <= ram_wdata;
  assign ram_rdata = ram_oe_n ? 16'h0 : mem[ram_addr[5:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          ch;
    int          cyc;
    bit          wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    bit          chk_rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input bit c, input int dcyc, input bit wr, input logic [17:0] a,
                          input logic [15:0] d, input bit chk_rd, input logic [15:0] rd);
    exp_t e;
    e.ch = c; e.cyc = dcyc; e.wr = wr; e.addr = a; e.wdata = d;
    e.chk_rd = chk_rd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: count strobe activity per transaction, score at each ch_done.
  int ce_cnt = 0, we_cnt = 0, oe_cnt = 0, doe_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      ce_cnt = 0; we_cnt = 0; oe_cnt = 0; doe_cnt = 0;
    end else begin
      if (!ram_ce_n)  ce_cnt++;
      if (!ram_we_n)  we_cnt++;
      if (!ram_oe_n)  oe_cnt++;
      if (ram_data_oe) doe_cnt++;
      if (ch_done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(ch_done), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_channel", 32'(ch_done), e.ch ? 32'h2 : 32'h1);
          chk("done_cycle",   32'(cyc), 32'(e.cyc));
          chk("ce_cycles",    32'(ce_cnt), 32'd3);
          chk("we_cycles",    32'(we_cnt), e.wr ? 32'd2 : 32'd0);
          chk("oe_cycles",    32'(oe_cnt), e.wr ? 32'd0 : 32'd2);
          chk("data_oe_cycles", 32'(doe_cnt), e.wr ? 32'd4 : 32'd0);
          chk("ram_addr",     32'(ram_addr), 32'(e.addr));
          if (e.wr) chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
          if (e.chk_rd) chk("ch_rdata", 32'(ch_rdata), 32'(e.rdata));
        end
        ce_cnt = 0; we_cnt = 0; oe_cnt = 0; doe_cnt = 0;
      end
    end
  end

  task automatic set_req(input bit c, input bit rd, input bit wr, input logic [17:0] a,
                         input logic [15:0] d);
    ch_rd[c] = rd;
    ch_wr[c] = wr;
    if (c) begin
      ch_addr[35:18]  = a;
      ch_wdata[31:16] = d;
    end else begin
      ch_addr[17:0]   = a;
      ch_wdata[15:0]  = d;
    end
  endtask

  task automatic clr_req(input bit c);
    ch_rd[c] = 1'b0;
    ch_wr[c] = 1'b0;
  endtask

  task automatic wait_done(input bit c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ch_done[c]) seen = 1'b1;
    end
    chk(c ? "wait_done_ch1" : "wait_done_ch0", 32'(seen), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_ch_done"}, 32'(ch_done), 32'd0);
    chk({tag, "_ce_n"},    32'(ram_ce_n), 32'd1);
    chk({tag, "_oe_n"},    32'(ram_oe_n), 32'd1);
    chk({tag, "_we_n"},    32'(ram_we_n), 32'd1);
    chk({tag, "_data_oe"}, 32'(ram_data_oe), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  initial begin
    rst = 1'b0; ch_rd = '0; ch_wr = '0; ch_addr = '0; ch_wdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_ch_rdata", 32'(ch_rdata), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Ch0 write 0x12 <- BEEF
    set_req(1'b0, 1'b0, 1'b1, 18'h00012, 16'hBEEF);
    push_exp(1'b0, cyc + 4, 1'b1, 18'h00012, 16'hBEEF, 1'b0, 16'h0);
    wait_done(1'b0);
    clr_req(1'b0);
    repeat (2) @(negedge clk);

    // Ch1 read 0x12 returns BEEF
    set_req(1'b1, 1'b1, 1'b0, 18'h00012, 16'h0);
    push_exp(1'b1, cyc + 4, 1'b0, 18'h00012, 16'h0, 1'b1, 16'hBEEF);
    wait_done(1'b1);
    clr_req(1'b1);
    repeat (2) @(negedge clk);

    // Ch1 write leaves ch_rdata untouched
    set_req(1'b1, 1'b0, 1'b1, 18'h00020, 16'h5555);
    push_exp(1'b1, cyc + 4, 1'b1, 18'h00020, 16'h5555, 1'b1, 16'hBEEF);
    wait_done(1'b1);
    clr_req(1'b1);
    repeat (2) @(negedge clk);

    // Both held: grants 0,1,0,1 five cycles apart
    set_req(1'b0, 1'b1, 1'b0, 18'h00020, 16'h0);
    set_req(1'b1, 1'b0, 1'b1, 18'h00031, 16'h0B0B);
    push_exp(1'b0, cyc + 4,  1'b0, 18'h00020, 16'h0,    1'b1, 16'h5555);
    push_exp(1'b1, cyc + 9,  1'b1, 18'h00031, 16'h0B0B, 1'b1, 16'h5555);
    push_exp(1'b0, cyc + 14, 1'b0, 18'h00020, 16'h0,    1'b1, 16'h5555);
    push_exp(1'b1, cyc + 19, 1'b1, 18'h00031, 16'h0B0B, 1'b1, 16'h5555);
    wait_done(1'b0);
    wait_done(1'b1);
    wait_done(1'b0);
    clr_req(1'b0);
    wait_done(1'b1);
    clr_req(1'b1);
    repeat (2) @(negedge clk);

    // rd and wr both set on ch0: performed as a write
    set_req(1'b0, 1'b1, 1'b1, 18'h00034, 16'h1234);
    push_exp(1'b0, cyc + 4, 1'b1, 18'h00034, 16'h1234, 1'b1, 16'h5555);
    wait_done(1'b0);
    clr_req(1'b0);
    repeat (2) @(negedge clk);

    // Ch1 read withdrawn during SETUP still completes
    set_req(1'b1, 1'b1, 1'b0, 18'h00034, 16'h0);
    push_exp(1'b1, cyc + 4, 1'b0, 18'h00034, 16'h0, 1'b1, 16'h1234);
    @(negedge clk);
    chk("busy_in_setup", 32'(busy), 32'd1);
    clr_req(1'b1);
    wait_done(1'b1);
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a ch0 write
    set_req(1'b0, 1'b0, 1'b1, 18'h00040, 16'h7777);
    repeat (2) @(negedge clk);
    chk("we_n_in_access", 32'(ram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b1, 18'h00041, 16'h8888);
    push_exp(1'b0, cyc + 4, 1'b1, 18'h00040, 16'h7777, 1'b1, 16'h0000);
    push_exp(1'b1, cyc + 9, 1'b1, 18'h00041, 16'h8888, 1'b1, 16'h0000);
    wait_done(1'b0);
    clr_req(1'b0);
    wait_done(1'b1);
    clr_req(1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, is the number of requester channels (legal range 1..8).
REQ-002 Parameter ADDR_W, default 18, is the memory address width.
REQ-003 Parameter DATA_W, default 16, is the memory data width.
REQ-004 Parameter WAIT_CYC, default 2, is the number of strobe-active cycles per access (legal range 1..15).
REQ-005 Port clk  in  1  is the single clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  is the reset, asynchronous and active-low.
REQ-007 Port ch_rd  in  NUM_CH  is the per-channel read request, level, held until ch_done.
REQ-008 Port ch_wr  in  NUM_CH  is the per-channel write request, level, held until ch_done.
REQ-009 Port ch_addr  in  NUM_CH*ADDR_W  is the per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port ch_wdata  in  NUM_CH*DATA_W  is the per-channel write data, packed the same way.
REQ-011 Port ch_done  out  NUM_CH  is a one-cycle completion pulse to the served channel.
REQ-012 Port ch_rdata  out  DATA_W  is the shared read-data register, valid from the ch_done cycle of a read.
REQ-013 Port busy  out  1  is high whenever the state is not IDLE.
REQ-014 Ports ram_addr out ADDR_W, ram_wdata out DATA_W and ram_rdata in DATA_W form the SRAM address/data side.
REQ-015 Port ram_data_oe  out  1  enables the tri-state data driver when high.
REQ-016 Ports ram_ce_n, ram_oe_n and ram_we_n, each out 1, are the active-low SRAM strobes.

Function
REQ-017 The FSM states SHALL be IDLE, SETUP, ACCESS and DONE, with the following transitions:
- IDLE->SETUP when any unmasked request is present.
- SETUP->ACCESS unconditionally.
- ACCESS->DONE after WAIT_CYC cycles.
- DONE->IDLE unconditionally.
REQ-018 In IDLE, grant SHALL be round-robin: the search starts at last_grant+1 modulo NUM_CH, and the first channel with ch_rd or ch_wr set wins.
REQ-019 On grant, the op, address, write data and channel index SHALL be latched; later changes on ch_* do not affect the transaction in flight.
REQ-020 If ch_rd and ch_wr are both set on the granted channel, the transaction SHALL be a write.
REQ-021 Strobe and driver behaviour per state:
- SETUP: ram_ce_n=0, with ram_oe_n and ram_we_n both 1.
- ACCESS: ram_ce_n=0, with ram_oe_n=0 for a read or ram_we_n=0 for a write.
- DONE and IDLE: all three strobes are 1.
REQ-022 For writes, ram_data_oe SHALL be 1 throughout SETUP, ACCESS and DONE, and 0 otherwise; for reads it SHALL always be 0.
REQ-023 ram_addr and ram_wdata SHALL come from the latched values and stay stable from SETUP through DONE.
REQ-024 On a read, ram_rdata SHALL be captured into ch_rdata at the clock edge that ends the last ACCESS cycle.
REQ-025 ch_rdata SHALL hold its value until the next read capture; writes do not alter it.
REQ-026 ch_done[g] SHALL be high exactly during the DONE cycle. Latency is a request sampled at the IDLE edge k giving ch_done high during cycle k+2+WAIT_CYC.
REQ-027 In the first IDLE cycle after DONE, the just-served channel SHALL be masked from arbitration, giving the requester one cycle to drop its request.
REQ-028 A request withdrawn mid-transaction SHALL NOT abort the access; ch_done still pulses.
REQ-029 The WAIT_CYC cycle counter SHALL be ceil(log2(WAIT_CYC+1)) bits wide and reload in SETUP.
REQ-030 Back-to-back requests on two channels SHALL be served alternately, with one IDLE cycle between transactions.

Reset
REQ-031 While rst=0, the block SHALL hold these values, independent of clk:
- state=IDLE and busy=0.
- ch_done=0 and ch_rdata=0.
- ram_ce_n, ram_oe_n and ram_we_n all 1.
- ram_data_oe=0, ram_addr=0 and ram_wdata=0.
- last_grant=NUM_CH-1, so channel 0 wins first.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no ch_done pulse; after release, arbitration restarts from channel 0.

Structure
REQ-033 State encodings and default widths (matching the existing MemAddr/MemValue ranges) SHALL live in the shared defines header.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter that takes the request vector, last_grant and mask, and returns the grant index plus a valid flag.

Verification
REQ-035 The bench SHALL run with NUM_CH=2 and WAIT_CYC=2 and cover these scenarios:
- Ch0 write 0x00012 <- 0xBEEF: we_n low for exactly 2 cycles, data_oe high for 4 cycles, ch_done[0] in cycle k+4.
- Ch1 read 0x00012 with the model returning 0xBEEF: ch_rdata=0xBEEF in the ch_done[1] cycle, and it still holds 0xBEEF after a later write.
- Ch0 and ch1 both held requesting: grants alternate 0,1,0,1, with each done 5 cycles apart.
- ch_rd=ch_wr=1 on ch0: a write is performed and oe_n stays 1.
- rst pulled low during ACCESS of a write: strobes go high immediately, there is no ch_done, and the next grant goes to ch0.
- Ch1 drops its request during SETUP: the access completes and ch_done[1] still pulses.
